// File: rtl/moving_ball_pkg.sv
// Shared types and constants for the LED tennis engine.
package moving_ball_pkg;

    localparam int unsigned LED_W = 16;

    localparam logic [LED_W-1:0] LED_P1_END = 16'h8000;
    localparam logic [LED_W-1:0] LED_P2_END = 16'h0001;

    typedef enum logic [1:0] {
        SERVE_P1,
        SERVE_P2,
        MOVE_R,
        MOVE_L
    } ball_state_e;

endpackage

// File: rtl/moving_ball_ctrl_if.sv
// Board-side signals of the tennis engine: two serve buttons in, LED bar out.
interface moving_ball_ctrl_if;
    import moving_ball_pkg::*;

    logic             serve_button_player1;
    logic             serve_button_player2;
    logic [LED_W-1:0] led;

    modport master (
        output serve_button_player1,
        output serve_button_player2,
        input  led
    );

    modport slave (
        input  serve_button_player1,
        input  serve_button_player2,
        output led
    );

endinterface

// File: rtl/moving_ball_ctrl_button_edge.sv
// 2-FF synchronizer followed by a rising-edge detector; one pulse per press.
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press
);

    logic sync1_q, sync2_q, prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press = sync2_q & ~prev_q;

endmodule

// File: rtl/moving_ball_ctrl.sv
// Tennis engine: serve/return FSM, step timer and one-hot ball register.
module moving_ball_ctrl
    import moving_ball_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    moving_ball_ctrl_if.slave  bus
);

    localparam int unsigned     CNT_W   = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_CYCLES - 1);

    logic p1_press, p2_press;

    button_edge u_edge_p1 (
        .clk    (clk),
        .reset  (reset),
        .button (bus.serve_button_player1),
        .press  (p1_press)
    );

    button_edge u_edge_p2 (
        .clk    (clk),
        .reset  (reset),
        .button (bus.serve_button_player2),
        .press  (p2_press)
    );

    ball_state_e      state_q, state_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    assign tick = ((state_q == MOVE_R) || (state_q == MOVE_L)) && (cnt_q == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SERVE_P1;
            led_q   <= LED_P1_END;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            cnt_q   <= cnt_d;
        end
    end

    // A return press at the receiving end beats a simultaneous tick.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        cnt_d   = '0;
        unique case (state_q)
            SERVE_P1: begin
                led_d = LED_P1_END;
                if (p1_press) state_d = MOVE_R;
            end
            SERVE_P2: begin
                led_d = LED_P2_END;
                if (p2_press) state_d = MOVE_L;
            end
            MOVE_R: begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                if (led_q == LED_P2_END) begin
                    if (p2_press) begin
                        state_d = MOVE_L;
                        cnt_d   = '0;
                    end else if (tick) begin
                        state_d = SERVE_P2;
                    end
                end else if (tick) begin
                    led_d = led_q >> 1;
                end
            end
            MOVE_L: begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                if (led_q == LED_P1_END) begin
                    if (p1_press) begin
                        state_d = MOVE_R;
                        cnt_d   = '0;
                    end else if (tick) begin
                        state_d = SERVE_P1;
                    end
                end else if (tick) begin
                    led_d = led_q << 1;
                end
            end
            default: begin
                state_d = SERVE_P1;
                led_d   = LED_P1_END;
            end
        endcase
    end

    assign bus.led = led_q;

endmodule

// File: tb/tb_moving_ball_ctrl.sv
// Self-checking bench: directed rally scenarios plus random button activity vs. a ball model.
module tb_moving_ball_ctrl;
    import moving_ball_pkg::*;

    localparam int unsigned STEP = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    moving_ball_ctrl_if bus_if ();

    moving_ball_ctrl #(.STEP_CYCLES(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Ball model: position index (15 = player 1 end), direction of travel
    // (0 = waiting for a serve, -1 toward player 2, +1 toward player 1),
    // cycles since the last serve/return, and sampled button level history.
    int       m_pos     = 15;
    int       m_dir     = 0;
    int       m_elapsed = 0;
    bit [2:0] h1        = '0;
    bit [2:0] h2        = '0;
    bit       pr1, pr2, recv_press;
    int       recv_end;

    function automatic logic [15:0] model_led();
        logic [15:0] one;
        one = 16'h0001;
        return one << m_pos;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pos     = 15;
            m_dir     = 0;
            m_elapsed = 0;
            h1        = '0;
            h2        = '0;
        end else begin
            // A level change seen two edges ago becomes a press acting now.
            pr1 = h1[1] & ~h1[2];
            pr2 = h2[1] & ~h2[2];
            h1  = {h1[1:0], bus_if.serve_button_player1};
            h2  = {h2[1:0], bus_if.serve_button_player2};
            if (m_dir == 0) begin
                if (m_pos == 15 && pr1) begin
                    m_dir = -1;
                    m_elapsed = 0;
                end else if (m_pos == 0 && pr2) begin
                    m_dir = 1;
                    m_elapsed = 0;
                end
            end else begin
                recv_end   = (m_dir < 0) ? 0 : 15;
                recv_press = (m_dir < 0) ? pr2 : pr1;
                if (m_pos == recv_end && recv_press) begin
                    m_dir     = -m_dir;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed % STEP == 0) begin
                        if (m_pos == recv_end) m_dir = 0;
                        else m_pos += m_dir;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input logic [15:0] exp);
        check({name, "_dut"}, bus_if.led, exp);
        check({name, "_model"}, model_led(), exp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset) check("led_vs_model", bus_if.led, model_led());
    end

    initial begin
        bus_if.serve_button_player1 = 1'b0;
        bus_if.serve_button_player2 = 1'b0;
        reset = 1'b1;
        wait_n(3);
        reset = 1'b0;
        wait_n(1);
        lit("reset_led", 16'h8000);
        wait_n(20);
        lit("idle_led", 16'h8000);

        bus_if.serve_button_player2 = 1'b1;
        wait_n(1);
        bus_if.serve_button_player2 = 1'b0;
        wait_n(10);
        lit("p2_ignored", 16'h8000);

        // P1 serve, no return: ball crosses and serve passes to P2.
        bus_if.serve_button_player1 = 1'b1;
        wait_n(1);
        bus_if.serve_button_player1 = 1'b0;
        wait_n(5);
        lit("serve_e6", 16'h8000);
        wait_n(1);
        lit("serve_e7", 16'h4000);
        wait_n(55);
        lit("serve_e62", 16'h0002);
        wait_n(1);
        lit("serve_e63", 16'h0001);
        wait_n(17);
        lit("miss_p2", 16'h0001);

        // P2 serve, P1 returns inside the end window.
        bus_if.serve_button_player2 = 1'b1;
        wait_n(1);
        bus_if.serve_button_player2 = 1'b0;
        wait_n(5);
        lit("p2serve_e6", 16'h0001);
        wait_n(1);
        lit("p2serve_e7", 16'h0002);
        wait_n(55);
        lit("p2serve_e62", 16'h4000);
        bus_if.serve_button_player1 = 1'b1;
        wait_n(1);
        bus_if.serve_button_player1 = 1'b0;
        lit("p1_window", 16'h8000);
        wait_n(5);
        lit("p1_hit_hold", 16'h8000);
        wait_n(1);
        lit("p1_hit_move", 16'h4000);

        // P2 returns the ball back.
        wait_n(55);
        lit("rally_e124", 16'h0002);
        bus_if.serve_button_player2 = 1'b1;
        wait_n(1);
        bus_if.serve_button_player2 = 1'b0;
        lit("p2_window", 16'h0001);
        wait_n(5);
        lit("p2_hit_hold", 16'h0001);
        wait_n(1);
        lit("p2_hit_move", 16'h0002);
        wait_n(70);
        lit("miss_p1", 16'h8000);

        // Held serve button fires exactly once.
        bus_if.serve_button_player1 = 1'b1;
        wait_n(130);
        lit("held_p1", 16'h0001);
        bus_if.serve_button_player1 = 1'b0;
        wait_n(5);

        // Asynchronous reset mid-flight.
        bus_if.serve_button_player2 = 1'b1;
        wait_n(1);
        bus_if.serve_button_player2 = 1'b0;
        wait_n(34);
        lit("mid_flight", 16'h0100);
        #1 reset = 1'b1;
        #1 lit("async_reset", 16'h8000);
        wait_n(2);
        reset = 1'b0;
        wait_n(1);
        lit("after_reset", 16'h8000);

        // Random button activity with occasional resets.
        repeat (4000) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0)
                bus_if.serve_button_player1 = ~bus_if.serve_button_player1;
            if ($urandom_range(0, 5) == 0)
                bus_if.serve_button_player2 = ~bus_if.serve_button_player2;
            if ($urandom_range(0, 1999) == 0) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        end
        bus_if.serve_button_player1 = 1'b0;
        bus_if.serve_button_player2 = 1'b0;
        wait_n(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
